// File: rtl/inj_scheduler.sv
// Round-robin injection scheduler: time-slices NUM_SRC ROM streamers onto one
// valid/ready injection port, tagging each flit with its source id.
module inj_scheduler #(
  parameter int NUM_SRC    = 4,
  parameter int BURST_LEN  = 30,
  parameter int SLICE      = 4,
  parameter int FIFO_DEPTH = 4,
  localparam int SW        = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_go,
  input  logic [NUM_SRC-1:0]     i_src_valid,
  input  logic [20*NUM_SRC-1:0]  i_src_data,
  output logic [NUM_SRC-1:0]     o_src_enable,
  output logic [19:0]            o_out_data,
  output logic [SW-1:0]          o_out_src,
  output logic                   o_out_valid,
  input  logic                   i_out_ready,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_protocol_err
);
  localparam int IW = ($clog2(BURST_LEN + 1) > 5) ? $clog2(BURST_LEN + 1) : 5;
  localparam int CW = $clog2(SLICE + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int FW = $clog2(FIFO_DEPTH + 1);
  localparam logic [FW:0]   DEPTH_W = (FW + 1)'(FIFO_DEPTH);
  localparam logic [FW-1:0] FULL_W  = FW'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_P  = PW'(FIFO_DEPTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_SWITCH, S_FLUSH, S_DONE} state_t;
  state_t r_state, w_state_nxt;

  logic [SW-1:0]              r_grant, w_grant_nxt;
  logic [NUM_SRC-1:0]         r_started;
  logic [NUM_SRC-1:0][IW-1:0] r_issued;
  logic [CW-1:0]              r_slice_cnt;
  logic                       r_en_q;
  logic                       r_err;

  logic [19:0]   r_mem_data [FIFO_DEPTH];
  logic [SW-1:0] r_mem_src  [FIFO_DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [FW-1:0] r_count;

  logic [NUM_SRC-1:0] w_grant_oh, w_elig;
  logic [FW:0]        w_credit;
  logic               w_slice_end, w_en, w_any_elig, w_cur_valid;
  logic               w_push, w_pop, w_err_set, w_regrant;

  function automatic logic [SW-1:0] wrap_add(input logic [SW-1:0] g, input int k);
    int s;
    s = int'(g) + k;
    if (s >= NUM_SRC) s -= NUM_SRC;
    return SW'(s);
  endfunction

  always_comb begin
    w_grant_oh = '0;
    w_grant_oh[r_grant] = 1'b1;
    for (int i = 0; i < NUM_SRC; i++) w_elig[i] = (r_issued[i] != IW'(BURST_LEN));
  end

  // In-flight flit reserves a FIFO slot so a full FIFO never sees a legal push.
  assign w_credit    = {1'b0, r_count} + {{FW{1'b0}}, r_en_q};
  assign w_slice_end = (r_slice_cnt == CW'(SLICE)) || !w_elig[r_grant];
  assign w_en        = (r_state == S_RUN) && !w_slice_end && (w_credit < DEPTH_W);
  assign o_src_enable = w_en ? w_grant_oh : '0;

  // Highest k first so the nearest eligible source after grant wins; k = NUM_SRC
  // is the current source itself, chosen only when nothing else is left.
  always_comb begin
    w_grant_nxt = r_grant;
    w_any_elig  = 1'b0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      if (w_elig[wrap_add(r_grant, k)]) begin
        w_grant_nxt = wrap_add(r_grant, k);
        w_any_elig  = 1'b1;
      end
    end
  end

  assign w_regrant = (r_state == S_SWITCH) && !r_en_q && w_any_elig;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (i_go) w_state_nxt = S_RUN;
      S_RUN:    if (w_slice_end) w_state_nxt = S_SWITCH;
      S_SWITCH: if (!r_en_q) w_state_nxt = w_any_elig ? S_RUN : S_FLUSH;
      S_FLUSH:  if (r_count == '0) w_state_nxt = S_DONE;
      default:  w_state_nxt = r_state;
    endcase
  end

  assign w_cur_valid = i_src_valid[r_grant];
  assign w_pop       = o_out_valid && i_out_ready;
  assign w_push      = w_cur_valid && ((r_count != FULL_W) || w_pop);
  assign w_err_set   = (|(i_src_valid & ~w_grant_oh)) || (r_en_q && !w_cur_valid) ||
                       (w_cur_valid && !r_en_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_grant     <= '0;
      r_started   <= '0;
      r_issued    <= '0;
      r_slice_cnt <= '0;
      r_en_q      <= 1'b0;
      r_err       <= 1'b0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_en_q  <= w_en && r_started[r_grant];
      if (w_err_set) r_err <= 1'b1;
      if (w_en) begin
        if (r_started[r_grant]) begin
          r_issued[r_grant] <= r_issued[r_grant] + IW'(1);
          r_slice_cnt       <= r_slice_cnt + CW'(1);
        end else begin
          r_started[r_grant] <= 1'b1;
        end
      end
      if (w_regrant) begin
        r_grant     <= w_grant_nxt;
        r_slice_cnt <= '0;
      end
      if (w_push) r_wptr <= (r_wptr == LAST_P) ? '0 : r_wptr + PW'(1);
      if (w_pop)  r_rptr <= (r_rptr == LAST_P) ? '0 : r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + FW'(1);
        2'b01:   r_count <= r_count - FW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wptr] <= i_src_data[int'(r_grant)*20 +: 20];
      r_mem_src[r_wptr]  <= r_grant;
    end
  end

  assign o_out_valid    = (r_count != '0);
  assign o_out_data     = o_out_valid ? r_mem_data[r_rptr] : '0;
  assign o_out_src      = o_out_valid ? r_mem_src[r_rptr] : '0;
  assign o_busy         = (r_state == S_RUN) || (r_state == S_SWITCH) || (r_state == S_FLUSH);
  assign o_done         = (r_state == S_DONE);
  assign o_protocol_err = r_err;

endmodule

// File: tb/tb_inj_scheduler.sv
// Bench for inj_scheduler: ROM-streamer source models, slice-order reference
// model, scoreboard monitor. Instance a uses defaults, b uses 2 sources x SLICE 30.
module tb_inj_scheduler;
  localparam int BL = 30;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic go = 1'b0, ready = 1'b1, sel = 1'b0;
  logic [3:0] inj = '0;
  int total = 0, bad = 0, popped = 0, occ = 0;

  logic [3:0]  a_sv, a_en;
  logic [79:0] a_sd;
  logic [19:0] a_od;
  logic [1:0]  a_os;
  logic        a_ov, a_busy, a_done, a_err;
  logic [1:0]  b_sv, b_en;
  logic [39:0] b_sd;
  logic [19:0] b_od;
  logic        b_os;
  logic        b_ov, b_busy, b_done, b_err;

  inj_scheduler u_a (
    .clk(clk), .rst(rst), .i_go(go & ~sel), .i_src_valid(a_sv), .i_src_data(a_sd),
    .o_src_enable(a_en), .o_out_data(a_od), .o_out_src(a_os), .o_out_valid(a_ov),
    .i_out_ready(ready), .o_busy(a_busy), .o_done(a_done), .o_protocol_err(a_err));

  inj_scheduler #(.NUM_SRC(2), .BURST_LEN(BL), .SLICE(30), .FIFO_DEPTH(DEPTH)) u_b (
    .clk(clk), .rst(rst), .i_go(go & sel), .i_src_valid(b_sv), .i_src_data(b_sd),
    .o_src_enable(b_en), .o_out_data(b_od), .o_out_src(b_os), .o_out_valid(b_ov),
    .i_out_ready(ready), .o_busy(b_busy), .o_done(b_done), .o_protocol_err(b_err));

  // Shared source models: ROM streamers whose first enable only activates them.
  logic [19:0] rom [4][BL];
  logic [19:0] m_sd [4];
  logic [3:0]  m_sv, m_st, m_en;
  int          m_ptr [4];

  assign m_en = sel ? {2'b00, b_en} : a_en;
  assign a_sv = sel ? 4'b0 : (m_sv | inj);
  assign b_sv = sel ? m_sv[1:0] : 2'b0;
  assign a_sd = {m_sd[3], m_sd[2], m_sd[1], m_sd[0]};
  assign b_sd = {m_sd[1], m_sd[0]};

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_sv <= '0;
      m_st <= '0;
      for (int i = 0; i < 4; i++) begin m_ptr[i] <= 0; m_sd[i] <= '0; end
    end else begin
      for (int i = 0; i < 4; i++) begin
        m_sv[i] <= 1'b0;
        if (m_en[i]) begin
          if (!m_st[i]) m_st[i] <= 1'b1;
          else begin
            m_sv[i]  <= 1'b1;
            m_sd[i]  <= rom[i][m_ptr[i] % BL];
            m_ptr[i] <= m_ptr[i] + 1;
          end
        end
      end
    end
  end

  logic        mv, mdone, mbusy, merr;
  logic [19:0] md;
  logic [2:0]  ms;
  assign mv    = sel ? b_ov : a_ov;
  assign md    = sel ? b_od : a_od;
  assign ms    = sel ? {2'b00, b_os} : {1'b0, a_os};
  assign mdone = sel ? b_done : a_done;
  assign mbusy = sel ? b_busy : a_busy;
  assign merr  = sel ? b_err : a_err;

  // FIFO occupancy seen from outside: flits delivered by sources minus flits taken.
  always @(posedge clk or negedge rst) begin
    if (!rst) occ <= 0;
    else occ <= occ + $countones(m_sv) - ((mv && ready) ? 1 : 0);
  end

  logic [22:0] expq [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (mv && ready) begin
        if (expq.size() == 0) begin
          total++; bad++;
          $display("FAIL extra_flit: got src=%0d data=%h want none", ms, md);
        end else begin
          chk("flit", 32'({ms, md}), 32'(expq.pop_front()));
        end
        popped++;
      end
      total++;
      if (occ > DEPTH) begin
        bad++;
        $display("FAIL fifo_occ: got %0d want <= %0d", occ, DEPTH);
      end
    end
  end

  // Reference order: grant 0 first, take min(slice, remaining), then the next
  // source round-robin that still has flits.
  task automatic build_exp(input int ns, input int sl);
    int rem [4];
    int g, take, left, s, k;
    for (int i = 0; i < 4; i++) rem[i] = (i < ns) ? BL : 0;
    left = ns * BL;
    g = 0;
    while (left > 0) begin
      take = (rem[g] < sl) ? rem[g] : sl;
      s = BL - rem[g];
      for (int w = s; w < s + take; w++) expq.push_back({3'(g), rom[g][w]});
      rem[g] -= take;
      left -= take;
      if (left > 0) begin
        k = 1;
        while (rem[(g + k) % ns] == 0) k++;
        g = (g + k) % ns;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; go = 1'b0; inj = '0; ready = 1'b1;
    @(posedge clk); #1;
    expq.delete();
    popped = 0;
    for (int i = 0; i < 4; i++)
      for (int w = 0; w < BL; w++) rom[i][w] = 20'($urandom);
    rst = 1'b1;
  endtask

  // Leaves the caller in cycle 1 (one edge after go).
  task automatic start(input int ns, input int sl);
    @(posedge clk); #1;
    go = 1'b1;
    build_exp(ns, sl);
    @(posedge clk); #1;
    go = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int maxc, input bit rnd);
    int n;
    n = 0;
    while (!mdone && n < maxc) begin
      @(posedge clk); #1;
      if (rnd) ready = 1'($urandom_range(0, 1));
      n++;
    end
    ready = 1'b1;
    total++;
    if (!mdone) begin
      bad++;
      $display("FAIL %s_timeout: got done=0 after %0d cycles want done=1", nm, n);
    end
  endtask

  task automatic end_checks(input string nm, input int nflits, input int err);
    chk({nm, "_count"}, 32'(popped), 32'(nflits));
    chk({nm, "_sb_empty"}, 32'(expq.size()), 0);
    chk({nm, "_busy"}, 32'(mbusy), 0);
    chk({nm, "_ovalid"}, 32'(mv), 0);
    chk({nm, "_err"}, 32'(merr), 32'(err));
  endtask

  initial begin
    do_reset();
    rst = 1'b0;
    #1;
    chk("rst_a", 32'({a_en, a_ov, a_od, a_os, a_busy, a_done, a_err}), 0);
    chk("rst_b", 32'({b_en, b_ov, b_od, b_os, b_busy, b_done, b_err}), 0);
    do_reset();

    // Full run, ready high, with first-flit latency
    start(4, 4);
    chk("t1_activate_en", 32'(a_en), 1);
    chk("t1_busy", 32'(a_busy), 1);
    @(posedge clk); #1;
    chk("t1_issue_en", 32'(a_en), 1);
    chk("t1_lat_c2", 32'(a_ov), 0);
    @(posedge clk); #1;
    chk("t1_lat_c3", 32'(a_ov), 0);
    @(posedge clk); #1;
    chk("t1_lat_c4", 32'(a_ov), 1);
    wait_done("t1", 3000, 1'b0);
    end_checks("t1", 120, 0);

    // Backpressure: FIFO fills to depth and enables stop
    do_reset();
    ready = 1'b0;
    start(4, 4);
    repeat (20) @(posedge clk);
    #1;
    for (int c = 0; c < 20; c++) begin
      chk("t2_en_stalled", 32'(a_en), 0);
      @(posedge clk); #1;
    end
    chk("t2_occ_full", 32'(occ), DEPTH);
    chk("t2_ovalid", 32'(a_ov), 1);
    chk("t2_no_pop", 32'(popped), 0);
    ready = 1'b1;
    wait_done("t2", 3000, 1'b0);
    end_checks("t2", 120, 0);

    // Random ready
    do_reset();
    start(4, 4);
    wait_done("t3", 5000, 1'b1);
    end_checks("t3", 120, 0);

    // Reset mid-burst, then restart with new ROM contents
    do_reset();
    start(4, 4);
    for (int c = 0; c < 2000 && popped < 17; c++) @(posedge clk);
    #1;
    chk("t5_reached17", 32'(popped >= 17), 1);
    rst = 1'b0;
    #1;
    chk("t5_async_clear", 32'({a_en, a_ov, a_od, a_os, a_busy, a_done, a_err}), 0);
    @(posedge clk); #1;
    chk("t5_edge_clear", 32'({a_en, a_ov, a_od, a_os, a_busy, a_done, a_err}), 0);
    do_reset();
    start(4, 4);
    wait_done("t5", 3000, 1'b0);
    end_checks("t5", 120, 0);

    // Spurious valid from source 2 while grant is 0
    do_reset();
    start(4, 4);
    chk("t6_err_before", 32'(a_err), 0);
    inj = 4'b0100;
    @(posedge clk); #1;
    inj = '0;
    chk("t6_err_set", 32'(a_err), 1);
    wait_done("t6", 3000, 1'b0);
    end_checks("t6", 120, 1);

    // Two sources, whole burst per grant
    rst = 1'b0;
    sel = 1'b1;
    do_reset();
    start(2, 30);
    chk("t4_activate_en", 32'(b_en), 1);
    wait_done("t4", 3000, 1'b0);
    end_checks("t4", 60, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1);
  end
endmodule

// File: doc/inj_scheduler.md
# inj_scheduler

Round-robin injection scheduler that sequences NUM_SRC stored-pattern injection buffers (20-bit flit ROM streamers with per-cycle `enable`, 1-cycle registered `out_valid`) onto a single router injection port. It time-slices the sources, issues one enable per cycle to the granted source, and buffers returned flits in a small FIFO. It presents the flits with a valid/ready handshake, tags each with its source id, and raises `done` once every source has delivered BURST_LEN flits.

## Interface
- NUM_SRC, 4, number of injection buffers (2..8)
- BURST_LEN, 30, flits stored per source
- SLICE, 4, max flits taken from one source per grant (1..BURST_LEN)
- FIFO_DEPTH, 4, output FIFO entries (≥2)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- go  in  1  start pulse; sampled in IDLE only
- src_valid  in  NUM_SRC  per-source out_valid
- src_data  in  20*NUM_SRC  per-source dataout; source i at bits [20i+19:20i]
- src_enable  out  NUM_SRC  per-source enable; one-hot or zero
- out_data  out  20  flit at FIFO head
- out_src  out  clog2(NUM_SRC)  source id of head flit
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  downstream accepts flit
- busy  out  1  state ≠ IDLE and ≠ DONE
- done  out  1  all sources complete, FIFO drained
- protocol_err  out  1  sticky; unexpected or missing src_valid

## Operation
- States: IDLE, RUN, SWITCH, FLUSH, DONE.
- IDLE -> RUN on `go`. `grant` = 0.
- Per source: `started` bit, 5+-bit `issued` counter (0..BURST_LEN). Per grant: `slice_cnt` (0..SLICE).
- RUN:
  - Assert `src_enable[grant]` iff `fifo_count + en_q < FIFO_DEPTH`, `issued[grant] < BURST_LEN`, and `slice_cnt < SLICE`.
  - `en_q` is a 1-bit register: 1 iff last cycle's enable went to an already-started source, so a flit is in flight.
  - Enable to an unstarted source sets `started` only.
  - Enable to a started source increments `issued[grant]` and `slice_cnt`, and sets `en_q` next cycle.
  - When `slice_cnt == SLICE` or `issued[grant] == BURST_LEN`, stop enabling and go to SWITCH.
- SWITCH:
  - Hold `src_enable` = 0 until `en_q` = 0.
  - Then pick the next source with `issued < BURST_LEN`, searching round-robin from `grant+1` and wrapping modulo NUM_SRC. Clear `slice_cnt` and return to RUN.
  - If no such source remains, go to FLUSH.
  - The current source is eligible only if no other source is.
- FLUSH -> DONE when FIFO is empty.
- DONE is terminal until reset. `go` is ignored.
- Capture: `src_valid[grant]` pushes `{grant, src_data[grant]}` into the FIFO.
- `protocol_err` sets on any of:
  - `src_valid[i]` for i ≠ grant;
  - `en_q` = 1 with no `src_valid[grant]`;
  - `src_valid[grant]` with `en_q` = 0.
- An unexpected flit from the granted source is still pushed if the FIFO has space, else dropped.
- FIFO: push and pop in the same cycle are allowed, and count is unchanged. The credit rule guarantees no push while full except on error.

## Timing
- Reset values: `src_enable` = 0, `out_valid` = 0, `out_data` = 0, `out_src` = 0, `busy` = 0, `done` = 0, `protocol_err` = 0. All counters, `started`, FIFO pointers and `en_q` cleared; state IDLE.
- `src_enable` is combinational from registered state and `fifo_count` (no combinational path from `src_valid` or `out_ready`).
- Cycle 0: `go` high. Cycle 1: RUN, `enable[0]` (activate). Cycle 2: `enable[0]` (issue). Cycle 3: `src_valid[0]`, captured at end of cycle. Cycle 4: `out_valid` = 1 with flit 0.
- Flit latency from issuing enable to `out_valid` is 2 cycles.
- Sustained throughput is 1 flit/cycle with `out_ready` held high. SWITCH costs ≥1 bubble cycle per grant change.
- `done` rises the cycle after FIFO empties in FLUSH, and `busy` falls in the same cycle.
- Reset mid-operation: immediate clear; in-flight flits are discarded.

## Test plan
- Defaults, `out_ready` = 1, `go`: 120 flits in order src0 w0-3, src1 w0-3, src2, src3, src0 w4-7, …. `out_src` is correct per flit, no `protocol_err`, and `done` is asserted after the 120th flit.
- `out_ready` = 0 after `go`: FIFO reaches 4 entries and `src_enable` stays 0. Releasing `out_ready` delivers all 120 flits with no loss or duplication.
- `out_ready` toggled randomly each cycle: scoreboard matches the per-source ROM contents in order, and `fifo_count` never exceeds 4.
- SLICE = 30, NUM_SRC = 2: src0 30 flits, then one SWITCH bubble, then src1 30 flits, then `done`.
- Assert `rst` low mid-burst (after 17 flits): all outputs are 0 next edge and the state is IDLE. After reset and new sources, `go` restarts from src0 w0.
- Inject `src_valid[2]` while grant = 0: `protocol_err` goes to 1 and stays 1, and scheduling continues.
